rv_decode_stage: RTL

Registered RISC-V (RV32I/RV64I base) instruction decode stage, replacing the former purely combinational field splitter. It accepts one 32-bit instruction word per valid/ready handshake and extracts opcode, register addresses, func3 and func7. It also classifies the instruction format, generates the sign-extended immediate, flags illegal opcodes, and presents the result one cycle later. It sits between the fetch stage and register-file read, with a 2-entry skid buffer so that backpressure never creates a combinational ready path.

---
 rtl/rv_decode_stage.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_stage
// Purpose  : Registered RV32I/RV64I instruction decode stage. Splits an
//            instruction word into its raw fields, classifies the format,
//            builds the sign-extended immediate and flags unsupported
//            opcodes. Results are held in a 2-entry skid buffer so that
//            in_ready depends only on registered state.
// Revision : 1.0 - initial registered decode stage with skid buffer
// ----------------------------------------------------------------------------
// Parameters
//   XLEN  width of out_imm (32 or 64)
//   PC_W  width of the PC sideband
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              discard every buffered instruction
//   in_valid/in_ready  upstream handshake; in_instr, in_pc accompany it
//   out_valid/out_ready downstream handshake
//   out_opcode/rd/func3/rs1/rs2/func7  raw instruction bit fields
//   out_fmt            R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   out_imm            sign-extended immediate (0 for R and ILL)
//   out_illegal        opcode outside the supported map
//   out_pc             PC of the presented instruction
// ============================================================================
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_func7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  // --------------------------------------------------------------------------
  // Opcode map and format codes
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] c_FMT_R   = 3'd0;
  localparam logic [2:0] c_FMT_I   = 3'd1;
  localparam logic [2:0] c_FMT_S   = 3'd2;
  localparam logic [2:0] c_FMT_B   = 3'd3;
  localparam logic [2:0] c_FMT_U   = 3'd4;
  localparam logic [2:0] c_FMT_J   = 3'd5;
  localparam logic [2:0] c_FMT_ILL = 3'd7;

  // One fully decoded instruction, as held in either buffer entry.
  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      func7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } dec_t;

  // Buffer occupancy: EMPTY, main only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input-side decode
  // --------------------------------------------------------------------------
  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm_ext;
  dec_t            w_dec;

  // Format classification and the 32-bit immediate. Every immediate is
  // already sign-extended to 32 bits here; widening to XLEN is a pure
  // replication of bit 31 below.
  always_comb begin : p_fmt_imm
    w_fmt   = c_FMT_ILL;
    w_imm32 = '0;
    case (in_instr[6:0])
      c_OP_REG: begin
        w_fmt = c_FMT_R;
      end
      c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM, c_OP_FENCE: begin
        w_fmt   = c_FMT_I;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      c_OP_STORE: begin
        w_fmt   = c_FMT_S;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      c_OP_BRANCH: begin
        w_fmt   = c_FMT_B;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_fmt   = c_FMT_U;
        w_imm32 = {in_instr[31:12], 12'b0};
      end
      c_OP_JAL: begin
        w_fmt   = c_FMT_J;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      // Anything else, including compressed encodings (opcode[1:0] != 11),
      // stays ILL with a zero immediate.
      default: begin
        w_fmt   = c_FMT_ILL;
        w_imm32 = '0;
      end
    endcase
  end

  // Widen the immediate to XLEN; U-type upper immediates are sign-extended
  // on RV64 like every other format.
  generate
    if (XLEN > 32) begin : g_imm_sext
      assign w_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_native
      assign w_imm_ext = w_imm32;
    end
  endgenerate

  // Raw field slices are passed through for every format, ILL included.
  always_comb begin : p_pack
    w_dec         = '0;
    w_dec.opcode  = in_instr[6:0];
    w_dec.rd      = in_instr[11:7];
    w_dec.func3   = in_instr[14:12];
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.func7   = in_instr[31:25];
    w_dec.fmt     = w_fmt;
    w_dec.imm     = w_imm_ext;
    w_dec.illegal = (w_fmt == c_FMT_ILL);
    w_dec.pc      = in_pc;
  end

  // --------------------------------------------------------------------------
  // Skid buffer control
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  dec_t   r_main;
  dec_t   r_skid;
  logic   w_acc;
  logic   w_pop;
  logic   w_load_main;
  logic   w_load_skid;
  logic   w_shift_skid;

  // Both handshake flags come straight from the state register, so neither
  // in_valid nor out_ready can reach in_ready combinationally.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_next
    w_state_nxt  = r_state;
    w_load_main  = 1'b0;
    w_load_skid  = 1'b0;
    w_shift_skid = 1'b0;
    if (flush) begin
      // Flush beats any same-cycle accept or pop; nothing is loaded.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            // Main is consumed and refilled in the same edge.
            w_load_main = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_state_nxt  = ST_ONE;
            w_shift_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Entry storage. Reset clears both entries so the outputs read zero;
  // flush only empties the state, the stale data is hidden by out_valid=0.
  always_ff @(posedge clk) begin : p_entries
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_dec;
      end else if (w_shift_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs always show the main entry
  // --------------------------------------------------------------------------
  assign out_opcode  = r_main.opcode;
  assign out_rd      = r_main.rd;
  assign out_func3   = r_main.func3;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_func7   = r_main.func7;
  assign out_fmt     = r_main.fmt;
  assign out_imm     = r_main.imm;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main.pc;

endmodule

`default_nettype wire
